// File: rtl/noc_input_port.sv
// Generic synchronous FIFO: DEPTH entries, combinational read of the head entry.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller must gate push_vld against count.
module noc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_vld,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, wrapping pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_vld) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_vld, pop_vld})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// NoC input port: buffers incoming flits, XY-routes each packet, forwards on grant.
// Latency: head push -> req_o two cycles later; grant -> valid_o/credit_o next cycle.
// Backpressure: credit_o returns one credit per pop; pushes beyond DEPTH are dropped.
module noc_input_port #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 5,
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             credit_o,
  output logic [4:0]       req_o,
  input  logic             grant_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             proto_err_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0] MY_X = 4'(X_COORD);
  localparam logic [3:0] MY_Y = 4'(Y_COORD);

  // One-hot output-port encoding: N, E, S, W, Local.
  localparam logic [4:0] PORT_N = 5'b00001;
  localparam logic [4:0] PORT_E = 5'b00010;
  localparam logic [4:0] PORT_S = 5'b00100;
  localparam logic [4:0] PORT_W = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       route_q, route_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             credit_q, credit_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic [WIDTH-1:0] head_flit;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;
  logic             pop;
  logic             push;

  // X first, then Y; Y grows northward.
  function automatic logic [4:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
    logic [4:0] r;
    if (dx > MY_X)      r = PORT_E;
    else if (dx < MY_X) r = PORT_W;
    else if (dy > MY_Y) r = PORT_N;
    else if (dy < MY_Y) r = PORT_S;
    else                r = PORT_L;
    return r;
  endfunction

  noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (data_i),
    .pop_vld  (pop),
    .head_dat (head_flit),
    .count    (fifo_cnt)
  );

  assign fifo_empty = (fifo_cnt == '0);

  // Request is withdrawn during a mid-packet bubble so a grant cannot pop an empty FIFO.
  assign req_o = (state_q == ACTIVE && !fifo_empty) ? route_q : 5'b0;

  // Wormhole control, pop decision, push acceptance and registered output values.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    data_d      = data_q;
    pop         = 1'b0;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_flit[WIDTH-1]) begin
            route_d = xy_route(head_flit[7:4], head_flit[3:0]);
            state_d = ACTIVE;
          end else begin
            // Stray body/tail flit with no open packet: drop it but still return its credit.
            pop         = 1'b1;
            proto_err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (grant_i && req_o != 5'b0) begin
          pop    = 1'b1;
          data_d = head_flit;
          if (head_flit[WIDTH-2]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    push       = valid_i && ((fifo_cnt < DEPTH_C) || pop);
    overflow_d = overflow_q || (valid_i && !push);
    valid_d    = pop && (state_q == ACTIVE);
    credit_d   = pop;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      route_q     <= 5'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign credit_o    = credit_q;
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;
endmodule
